// File: rtl/mem_byte_sequencer_if.sv
// Request/response bus between the core and mem_byte_sequencer.
interface mem_byte_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_error, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_error, resp_rdata
    );
endinterface

// File: rtl/mem_byte_sequencer.sv
// Splits RISC-V loads/stores into byte accesses on a 2048x8 single-read/single-write array.
// Optional: define MEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module mem_byte_sequencer #(
    parameter int unsigned MEM_ADDR_WIDTH = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mem_byte_sequencer_if.slave       bus,
    output logic                      mem_write_enable,
    output logic [MEM_ADDR_WIDTH-1:0] mem_write_address,
    output logic [7:0]                mem_write_data,
    output logic                      mem_read_enable,
    output logic [MEM_ADDR_WIDTH-1:0] mem_read_address,
    input  logic [7:0]                mem_read_data
);

    localparam int unsigned AW = MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d, cnt_nxt;
    logic [2:0]    len_q, len_d;
    logic          uns_q, uns_d;
    logic [AW-1:0] base_q, base_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rbuf_q, rbuf_d, rbuf_merged;
    logic [1:0]    cap_idx;

    logic          we_d, re_d;
    logic [AW-1:0] waddr_d, raddr_d;
    logic [7:0]    wbyte_d;

    logic          resp_valid_q, resp_valid_d;
    logic          resp_error_q, resp_error_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic          ready_c, accept;
    logic          f3_ok, misaligned;
    logic [2:0]    req_len;
    logic [AW-1:0] req_base;

    assign ready_c        = (state_q == S_IDLE) && rst_n;
    assign accept         = bus.req_valid && ready_c;
    assign req_base       = bus.req_addr[AW-1:0];
    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_error = resp_error_q;
    assign bus.resp_rdata = resp_rdata_q;

    if (AW < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.req_addr[31:AW];
    end

    // Extend an assembled little-endian load to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [2:0]  len,
                                                input logic        uns);
        logic [31:0] res;
        case (len)
            3'd1:    res = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            3'd2:    res = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Request decode: access size and funct3 legality.
    always_comb begin
        req_len = 3'd1;
        f3_ok   = 1'b0;
        case (bus.req_funct3[1:0])
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            2'b10:   req_len = 3'd4;
            default: req_len = 3'd1;
        endcase
        if (bus.req_write) begin
            f3_ok = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
        end else begin
            f3_ok = (bus.req_funct3[1:0] != 2'b11) && !(bus.req_funct3[2] && bus.req_funct3[1]);
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = ((req_len == 3'd2) && bus.req_addr[0]) ||
                        ((req_len == 3'd4) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        uns_d        = uns_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        waddr_d      = '0;
        raddr_d      = '0;
        wbyte_d      = '0;
        resp_valid_d = 1'b0;
        resp_error_d = resp_error_q;
        resp_rdata_d = resp_rdata_q;

        cnt_nxt     = cnt_q + 3'd1;
        cap_idx     = cnt_q[1:0] - 2'd1;
        rbuf_merged = rbuf_q;
        // Data read in the previous cycle belongs to byte cnt-1.
        if (cnt_q != 3'd0) begin
            rbuf_merged[{cap_idx, 3'b000} +: 8] = mem_read_data;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    base_d  = req_base;
                    wdata_d = bus.req_wdata;
                    len_d   = req_len;
                    uns_d   = bus.req_funct3[2];
                    cnt_d   = 3'd0;
                    rbuf_d  = '0;
                    if (!f3_ok || misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                    end else if (bus.req_write) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        waddr_d = req_base;
                        wbyte_d = bus.req_wdata[7:0];
                    end else begin
                        state_d = S_READ;
                        re_d    = 1'b1;
                        raddr_d = req_base;
                    end
                end
            end
            S_WRITE: begin
                if (cnt_nxt < len_q) begin
                    cnt_d   = cnt_nxt;
                    we_d    = 1'b1;
                    waddr_d = base_q + AW'(cnt_nxt);
                    wbyte_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            S_READ: begin
                rbuf_d = rbuf_merged;
                cnt_d  = cnt_nxt;
                if (cnt_nxt < len_q) begin
                    re_d    = 1'b1;
                    raddr_d = base_q + AW'(cnt_nxt);
                end
                if (cnt_q == len_q) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = load_extend(rbuf_merged, len_q, uns_q);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            len_q             <= 3'd1;
            uns_q             <= 1'b0;
            base_q            <= '0;
            wdata_q           <= '0;
            rbuf_q            <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            mem_read_enable   <= 1'b0;
            mem_read_address  <= '0;
            resp_valid_q      <= 1'b0;
            resp_error_q      <= 1'b0;
            resp_rdata_q      <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            len_q             <= len_d;
            uns_q             <= uns_d;
            base_q            <= base_d;
            wdata_q           <= wdata_d;
            rbuf_q            <= rbuf_d;
            mem_write_enable  <= we_d;
            mem_write_address <= waddr_d;
            mem_write_data    <= wbyte_d;
            mem_read_enable   <= re_d;
            mem_read_address  <= raddr_d;
            resp_valid_q      <= resp_valid_d;
            resp_error_q      <= resp_error_d;
            resp_rdata_q      <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed self-checking bench for mem_byte_sequencer with a 2048x8 array model.
module tb_mem_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mem_write_enable;
    logic [10:0] mem_write_address;
    logic [7:0]  mem_write_data;
    logic        mem_read_enable;
    logic [10:0] mem_read_address;
    logic [7:0]  mem_read_data;

    mem_byte_sequencer_if bus ();

    mem_byte_sequencer #(.MEM_ADDR_WIDTH(11)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus.slave),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_enable   (mem_read_enable),
        .mem_read_address  (mem_read_address),
        .mem_read_data     (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read, single-write byte array.
    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
        if (mem_read_enable)  mem_read_data <= mem[mem_read_address];
    end

    int n_cmp = 0;
    int n_err = 0;

    int          cyc;
    int          resp_cyc;
    logic        resp_err_s;
    logic [31:0] resp_data_s;
    int wr_addr[$], wr_data[$], wr_cyc[$], rd_addr[$], rd_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0;
        resp_cyc = 0;
        resp_err_s = 1'b0;
        resp_data_s = '0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        rd_addr.delete(); rd_cyc.delete();
    endtask

    // Advance to the next cycle's negedge and log what the DUT shows there.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (mem_write_enable) begin
            wr_addr.push_back(int'(mem_write_address));
            wr_data.push_back(int'(mem_write_data));
            wr_cyc.push_back(cyc);
        end
        if (mem_read_enable) begin
            rd_addr.push_back(int'(mem_read_address));
            rd_cyc.push_back(cyc);
        end
        if (bus.resp_valid && resp_cyc == 0) begin
            resp_cyc    = cyc;
            resp_err_s  = bus.resp_error;
            resp_data_s = bus.resp_rdata;
        end
    endtask

    task automatic run(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int exp_cyc, input logic exp_err, input logic [31:0] exp_data);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        clear_log();
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        step();
        bus.req_valid  = 1'b0;
        for (int i = 0; i < 10 && resp_cyc == 0; i++) step();
        step();
        check({tag, "_cycle"}, resp_cyc, exp_cyc);
        check({tag, "_err"}, 32'(resp_err_s), 32'(exp_err));
        check({tag, "_rdata"}, resp_data_s, exp_data);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        clear_log();

        repeat (3) @(negedge clk);
        check("rst_ready",  32'(bus.req_ready), 32'd0);
        check("rst_rvalid", 32'(bus.resp_valid), 32'd0);
        check("rst_rerr",   32'(bus.resp_error), 32'd0);
        check("rst_rdata",  bus.resp_rdata, 32'd0);
        check("rst_we",     32'(mem_write_enable), 32'd0);
        check("rst_re",     32'(mem_read_enable), 32'd0);
        rst_n = 1'b1;
        step();

        // Word store, byte-serial little-endian.
        run("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5, 1'b0, 32'h0);
        check("sw100_nwr", wr_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sw100_addr%0d", k), wr_addr[k], 32'h100 + k);
            check($sformatf("sw100_cyc%0d", k), wr_cyc[k], k + 1);
        end
        check("sw100_data0", wr_data[0], 32'hEF);
        check("sw100_data3", wr_data[3], 32'hDE);

        run("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 6, 1'b0, 32'hDEADBEEF);
        check("lw100_nrd", rd_addr.size(), 4);
        check("lw100_rd3", rd_addr[3], 32'h103);
        check("lw100_rdcyc3", rd_cyc[3], 4);
        run("lh102",  1'b0, 3'b001, 32'h102, 32'h0, 4, 1'b0, 32'hFFFFDEAD);
        run("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 4, 1'b0, 32'h0000DEAD);
        run("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 3, 1'b0, 32'hFFFFFFDE);
        run("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 3, 1'b0, 32'h000000DE);
        run("lb_trunc", 1'b0, 3'b000, 32'h12345101, 32'h0, 3, 1'b0, 32'hFFFFFFBE);

        // Preload the wrap-around bytes.
        run("sb7fe", 1'b1, 3'b000, 32'h7FE, 32'h11, 2, 1'b0, 32'h0);
        run("sb7ff", 1'b1, 3'b000, 32'h7FF, 32'h22, 2, 1'b0, 32'h0);
        run("sb000", 1'b1, 3'b000, 32'h000, 32'h33, 2, 1'b0, 32'h0);
        run("sb001", 1'b1, 3'b000, 32'h001, 32'h44, 2, 1'b0, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
        run("lw7fe", 1'b0, 3'b010, 32'h7FE, 32'h0, 1, 1'b1, 32'h0);
        check("lw7fe_nrd", rd_addr.size(), 0);
        run("lh101", 1'b0, 3'b001, 32'h101, 32'h0, 1, 1'b1, 32'h0);
`else
        run("lw7fe", 1'b0, 3'b010, 32'h7FE, 32'h0, 6, 1'b0, 32'h44332211);
        check("lw7fe_nrd", rd_addr.size(), 4);
        check("lw7fe_rd0", rd_addr[0], 32'h7FE);
        check("lw7fe_rd1", rd_addr[1], 32'h7FF);
        check("lw7fe_rd2", rd_addr[2], 32'h000);
        check("lw7fe_rd3", rd_addr[3], 32'h001);
        run("lh101", 1'b0, 3'b001, 32'h101, 32'h0, 4, 1'b0, 32'hFFFFADBE);
`endif

        // Illegal funct3 values.
        run("ld011", 1'b0, 3'b011, 32'h100, 32'h0, 1, 1'b1, 32'h0);
        check("ld011_nen", wr_addr.size() + rd_addr.size(), 0);
        run("st100", 1'b1, 3'b100, 32'h100, 32'h12345678, 1, 1'b1, 32'h0);
        check("st100_nwr", wr_addr.size(), 0);
        run("lhu100", 1'b0, 3'b101, 32'h100, 32'h0, 4, 1'b0, 32'h0000BEEF);

        // Reset in the middle of a store.
        run("sw200z", 1'b1, 3'b010, 32'h200, 32'h0, 5, 1'b0, 32'h0);
        clear_log();
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h200;
        bus.req_wdata  = 32'hA5A5A5A5;
        step();
        bus.req_valid  = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("mrst_we_c3", 32'(mem_write_enable), 32'd0);
        check("mrst_ready_c3", 32'(bus.req_ready), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("mrst_ready_rel", 32'(bus.req_ready), 32'd1);
        repeat (4) step();
        check("mrst_nwr", wr_addr.size(), 2);
        check("mrst_wr1", wr_addr[1], 32'h201);
        check("mrst_noresp", resp_cyc, 0);
        run("lhu200", 1'b0, 3'b101, 32'h200, 32'h0, 4, 1'b0, 32'h0000A5A5);
        run("lhu202", 1'b0, 3'b101, 32'h202, 32'h0, 4, 1'b0, 32'h00000000);

        // req_valid held across two byte stores.
        clear_log();
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h300;
        bus.req_wdata  = 32'h5A;
        step();
        check("b2b_ready_c1", 32'(bus.req_ready), 32'd0);
        bus.req_addr  = 32'h301;
        bus.req_wdata = 32'h6B;
        step();
        check("b2b_ready_c2", 32'(bus.req_ready), 32'd0);
        check("b2b_resp_c2", 32'(bus.resp_valid), 32'd1);
        step();
        check("b2b_ready_c3", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        repeat (3) step();
        check("b2b_nwr", wr_addr.size(), 2);
        check("b2b_addr0", wr_addr[0], 32'h300);
        check("b2b_data0", wr_data[0], 32'h5A);
        check("b2b_cyc0", wr_cyc[0], 1);
        check("b2b_addr1", wr_addr[1], 32'h301);
        check("b2b_data1", wr_data[1], 32'h6B);
        check("b2b_cyc1", wr_cyc[1], 4);
        run("lhu300", 1'b0, 3'b101, 32'h300, 32'h0, 4, 1'b0, 32'h00006B5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
